// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and small op-decode helpers for the
// RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DIV_RUN  = 2'b01,
        S_DIV_HOLD = 2'b10
    } div_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [2:0] op;
    } mul_tag_t;

    localparam mul_tag_t TAG_NONE = '{valid: 1'b0, rd: 5'd0, op: 3'b000};

    function automatic logic is_div(input logic [2:0] op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        case (op)
            OP_REM, OP_REMU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic div_signed(input logic [2:0] op);
        case (op)
            OP_DIV, OP_REM: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // MUL keeps only the low half, so its signedness does not matter
    function automatic logic mul_a_signed(input logic [2:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic mul_b_signed(input logic [2:0] op);
        case (op)
            OP_MUL, OP_MULH: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// cycle, XLEN steps after start, done held until the next clock.
module muldiv_divider
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int            CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);

    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [CW-1:0]   cnt_r;
    logic            run_r;
    logic [XLEN:0]   shift_s;
    logic [XLEN:0]   diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, dvs_r};
    end

    // Step state: load on start, shift one bit per cycle, retire on done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_r <= {XLEN{1'b0}};
            rem_r <= {XLEN{1'b0}};
            dvs_r <= {XLEN{1'b0}};
            cnt_r <= CNT_ZERO;
            run_r <= 1'b0;
        end else if (kill) begin
            cnt_r <= CNT_ZERO;
            run_r <= 1'b0;
        end else if (start) begin
            quo_r <= dividend;
            rem_r <= {XLEN{1'b0}};
            dvs_r <= divisor;
            cnt_r <= CNT_LOAD;
            run_r <= 1'b1;
        end else if (run_r && (cnt_r != CNT_ZERO)) begin
            if (!diff_s[XLEN]) begin
                rem_r <= diff_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b1};
            end else begin
                rem_r <= shift_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b0};
            end
            cnt_r <= cnt_r - CNT_ONE;
        end else if (done) begin
            run_r <= 1'b0;
        end
    end

    assign done      = run_r && (cnt_r == CNT_ZERO);
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execution unit: pipelined multiplier plus iterative
// divider sharing one in-order registered output port with flush support.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);
    localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO2    = {(2*XLEN){1'b0}};

    div_state_e        state_r;
    div_state_e        state_s;
    mul_tag_t          mul_tag_r  [MUL_STAGES];
    logic [2*XLEN-1:0] mul_prod_r [MUL_STAGES];
    logic [2*XLEN-1:0] mul_a_wide_s;
    logic [2*XLEN-1:0] mul_b_wide_s;
    logic [2*XLEN-1:0] mul_prod_s;
    logic [XLEN-1:0]   mul_res_s;
    mul_tag_t          mul_last_s;

    logic              out_valid_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rd_out_r;
    logic              busy_r;

    logic              stall_s;
    logic              pipe_busy_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              mul_acc_s;
    logic              div_acc_s;
    logic              special_s;

    logic [XLEN-1:0]   div_a_r;
    logic [XLEN-1:0]   div_b_r;
    logic [2:0]        div_op_r;
    logic [4:0]        div_rd_r;
    logic              div_setup_r;
    logic              a_neg_s;
    logic              b_neg_s;
    logic              q_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN-1:0]   q_fix_s;
    logic [XLEN-1:0]   r_fix_s;
    logic [XLEN-1:0]   div_spec_s;
    logic [XLEN-1:0]   div_res_s;
    logic              div_start_s;
    logic              div_done_s;
    logic              div_load_s;
    logic [XLEN-1:0]   div_quo_s;
    logic [XLEN-1:0]   div_rem_s;

    // Request decode; a held output freezes the whole multiplier
    always_comb begin
        stall_s     = out_valid_r && !out_ready;
        pipe_busy_s = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            pipe_busy_s = pipe_busy_s | mul_tag_r[i].valid;
        end
        accept_s  = in_valid && in_ready_s && !flush;
        mul_acc_s = accept_s && !is_div(op);
        div_acc_s = accept_s && is_div(op);
        special_s = (b == ZERO) ||
                    (div_signed(op) && (a == MIN_NEG) && (b == ALL_ONES));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; special divides skip the iterative run entirely
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (div_acc_s) begin
                        state_s = special_s ? S_DIV_HOLD : S_DIV_RUN;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_DIV_RUN: begin
                    if (div_done_s) begin
                        state_s = S_DIV_HOLD;
                    end else begin
                        state_s = S_DIV_RUN;
                    end
                end
                S_DIV_HOLD: begin
                    if (out_valid_r && out_ready) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DIV_HOLD;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // FSM outputs: request gating, divider kick-off and result capture
    always_comb begin
        in_ready_s  = (state_r == S_IDLE) && !stall_s &&
                      !(in_valid && is_div(op) && pipe_busy_s);
        div_start_s = (state_r == S_DIV_RUN) && div_setup_r;
        div_load_s  = ((state_r == S_DIV_HOLD) && div_setup_r) ||
                      ((state_r == S_DIV_RUN) && div_done_s);
    end

    // Divide operand capture; the cycle after accept is the setup cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_a_r     <= ZERO;
            div_b_r     <= ZERO;
            div_op_r    <= OP_DIV;
            div_rd_r    <= 5'd0;
            div_setup_r <= 1'b0;
        end else if (flush) begin
            div_setup_r <= 1'b0;
        end else if (div_acc_s) begin
            div_a_r     <= a;
            div_b_r     <= b;
            div_op_r    <= op;
            div_rd_r    <= rd_in;
            div_setup_r <= 1'b1;
        end else begin
            div_setup_r <= 1'b0;
        end
    end

    // Magnitudes, sign fix-up and the RISC-V special-case results
    always_comb begin
        a_neg_s = div_signed(div_op_r) && div_a_r[XLEN-1];
        b_neg_s = div_signed(div_op_r) && div_b_r[XLEN-1];
        a_mag_s = a_neg_s ? (~div_a_r + ONE) : div_a_r;
        b_mag_s = b_neg_s ? (~div_b_r + ONE) : div_b_r;
        q_neg_s = (a_neg_s ^ b_neg_s) && (div_b_r != ZERO);
        q_fix_s = q_neg_s ? (~div_quo_s + ONE) : div_quo_s;
        r_fix_s = a_neg_s ? (~div_rem_s + ONE) : div_rem_s;
        if (div_b_r == ZERO) begin
            div_spec_s = is_rem(div_op_r) ? div_a_r : ALL_ONES;
        end else begin
            div_spec_s = is_rem(div_op_r) ? ZERO : MIN_NEG;
        end
        if (state_r == S_DIV_HOLD) begin
            div_res_s = div_spec_s;
        end else begin
            div_res_s = is_rem(div_op_r) ? r_fix_s : q_fix_s;
        end
    end

    muldiv_divider #(
        .XLEN (XLEN)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (flush),
        .start     (div_start_s),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Modulo-2^(2*XLEN) product of extended operands is exact for every sign mix
    always_comb begin
        mul_a_wide_s = {{XLEN{mul_a_signed(op) & a[XLEN-1]}}, a};
        mul_b_wide_s = {{XLEN{mul_b_signed(op) & b[XLEN-1]}}, b};
        mul_prod_s   = mul_a_wide_s * mul_b_wide_s;
        mul_last_s   = mul_tag_r[MUL_STAGES-1];
        if (mul_last_s.op == OP_MUL) begin
            mul_res_s = mul_prod_r[MUL_STAGES-1][XLEN-1:0];
        end else begin
            mul_res_s = mul_prod_r[MUL_STAGES-1][2*XLEN-1:XLEN];
        end
    end

    // Multiplier pipeline: product register then delay chain, frozen on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_tag_r[i]  <= TAG_NONE;
                mul_prod_r[i] <= ZERO2;
            end
        end else if (flush) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_tag_r[i].valid <= 1'b0;
            end
        end else if (!stall_s) begin
            mul_tag_r[0]  <= '{valid: mul_acc_s, rd: rd_in, op: op};
            mul_prod_r[0] <= mul_prod_s;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_tag_r[i]  <= mul_tag_r[i-1];
                mul_prod_r[i] <= mul_prod_r[i-1];
            end
        end
    end

    // Shared output register; multiply and divide completions never collide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= ZERO;
            rd_out_r    <= 5'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (stall_s) begin
            out_valid_r <= 1'b1;
        end else if (mul_last_s.valid) begin
            out_valid_r <= 1'b1;
            result_r    <= mul_res_s;
            rd_out_r    <= mul_last_s.rd;
        end else if (div_load_s) begin
            out_valid_r <= 1'b1;
            result_r    <= div_res_s;
            rd_out_r    <= div_rd_r;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    // Busy trails the in-flight state by one cycle and drops at once on flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else if (flush) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= pipe_busy_s || (state_r != S_IDLE) || out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign rd_out    = rd_out_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=2).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        rd_in    = r;
    endtask

    task automatic run_mul(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] r, input logic [31:0] exp, input string tag);
        drive(o, x, y, r);
        chk1({tag, " in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1({tag, " early valid"}, out_valid, 1'b0);
        tick();
        chk1({tag, " busy"}, busy, 1'b1);
        chk1({tag, " valid T+1"}, out_valid, 1'b0);
        tick();
        chk1({tag, " valid T+2"}, out_valid, 1'b1);
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, r});
        tick();
    endtask

    task automatic run_div_slow(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] r, input logic [31:0] exp, input string tag);
        int early;
        drive(o, x, y, r);
        chk1({tag, " in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        early = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
        end
        chk({tag, " early valid/ready"}, early, 32'd0);
        tick();
        chk1({tag, " valid T+34"}, out_valid, 1'b1);
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, r});
        tick();
        chk1({tag, " valid after take"}, out_valid, 1'b0);
    endtask

    task automatic run_div_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] r, input logic [31:0] exp, input string tag);
        drive(o, x, y, r);
        chk1({tag, " in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1({tag, " valid T"}, out_valid, 1'b0);
        tick();
        chk1({tag, " valid T+1"}, out_valid, 1'b1);
        chk({tag, " result"}, result, exp);
        chk({tag, " rd"}, {27'd0, rd_out}, {27'd0, r});
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = OP_MUL;
        a         = 32'd0;
        b         = 32'd0;
        rd_in     = 5'd0;
        out_ready = 1'b1;
        tick();
        tick();
        chk1("rst out_valid", out_valid, 1'b0);
        chk("rst result", result, 32'd0);
        chk("rst rd_out", {27'd0, rd_out}, 32'd0);
        chk1("rst busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("post-rst in_ready", in_ready, 1'b1);

        run_mul(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, "mulh");
        run_mul(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, "mulhsu");
        run_mul(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFEB, "mul");
        run_mul(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, "mulhu");

        // three back-to-back multiplies
        drive(OP_MUL, 32'd2, 32'd3, 5'd1);
        tick();
        drive(OP_MUL, 32'd4, 32'd5, 5'd2);
        tick();
        drive(OP_MUL, 32'd6, 32'd7, 5'd3);
        tick();
        in_valid = 1'b0;
        chk1("b2b valid 1", out_valid, 1'b1);
        chk("b2b result 1", result, 32'd6);
        chk("b2b rd 1", {27'd0, rd_out}, 32'd1);
        tick();
        chk1("b2b valid 2", out_valid, 1'b1);
        chk("b2b result 2", result, 32'd20);
        chk("b2b rd 2", {27'd0, rd_out}, 32'd2);
        tick();
        chk1("b2b valid 3", out_valid, 1'b1);
        chk("b2b result 3", result, 32'd42);
        chk("b2b rd 3", {27'd0, rd_out}, 32'd3);
        tick();
        chk1("b2b drained", out_valid, 1'b0);
        chk1("b2b busy tail", busy, 1'b1);
        tick();
        chk1("b2b busy off", busy, 1'b0);

        // backpressure holds output and blocks new requests
        out_ready = 1'b0;
        drive(OP_MUL, 32'd3, 32'd3, 5'd4);
        tick();
        drive(OP_MUL, 32'd5, 32'd5, 5'd5);
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk1("bp valid", out_valid, 1'b1);
            chk("bp result", result, 32'd9);
            chk("bp rd", {27'd0, rd_out}, 32'd4);
            chk1("bp in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk1("bp second valid", out_valid, 1'b1);
        chk("bp second result", result, 32'd25);
        chk("bp second rd", {27'd0, rd_out}, 32'd5);
        tick();

        run_div_slow(OP_DIV,  32'hFFFF_FFF9, 32'd2,  5'd6, 32'hFFFF_FFFD, "div");
        run_div_slow(OP_REM,  32'hFFFF_FFF9, 32'd2,  5'd7, 32'hFFFF_FFFF, "rem");
        run_div_slow(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd8, 32'h0FFF_FFFF, "divu");
        run_div_slow(OP_REMU, 32'd100,       32'd7,  5'd9, 32'd2,         "remu");

        run_div_fast(OP_DIVU, 32'd9,         32'd0,         5'd14, 32'hFFFF_FFFF, "divu by 0");
        run_div_fast(OP_REM,  32'd5,         32'd0,         5'd15, 32'd5,         "rem by 0");
        run_div_fast(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, "div ovf");
        run_div_fast(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         "rem ovf");

        // flush at T+10 of a divide, then a multiply at the next edge
        drive(OP_DIV, 32'd100, 32'd3, 5'd18);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("div flush valid", out_valid, 1'b0);
        chk1("div flush busy", busy, 1'b0);
        run_mul(OP_MUL, 32'd6, 32'd7, 5'd20, 32'd42, "post-div-flush mul");
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0) cnt++;
        end
        chk("div flush stray result", cnt, 32'd0);

        // flush at T+1 of a multiply, new multiply accepted right after
        drive(OP_MUL, 32'd9, 32'd9, 5'd21);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk1("mul flush valid", out_valid, 1'b0);
        chk1("mul flush busy", busy, 1'b0);
        drive(OP_MUL, 32'd3, 32'd4, 5'd23);
        chk1("mul flush in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1("mul flush no old result", out_valid, 1'b0);
        tick();
        chk1("mul flush new T+1", out_valid, 1'b0);
        tick();
        chk1("mul flush new valid", out_valid, 1'b1);
        chk("mul flush new result", result, 32'd12);
        chk("mul flush new rd", {27'd0, rd_out}, 32'd23);
        tick();

        // flush blocks a same-cycle request
        drive(OP_MUL, 32'd2, 32'd2, 5'd22);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        chk1("flush blocks accept", out_valid, 1'b0);
        chk1("flush blocks busy", busy, 1'b0);

        // reset in the middle of a divide
        drive(OP_DIV, 32'd100, 32'd3, 5'd24);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("mid-div rst valid", out_valid, 1'b0);
        chk("mid-div rst result", result, 32'd0);
        chk("mid-div rst rd", {27'd0, rd_out}, 32'd0);
        chk1("mid-div rst busy", busy, 1'b0);
        chk1("mid-div rst in_ready", in_ready, 1'b1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0) cnt++;
        end
        chk("mid-div rst stray result", cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
